// File: rtl/car_power_ctrl_if.sv
// Driver-control / car-status bundle between the input layer and the power sequencer.
// The master side drives the debounced controls; the slave side returns the car status.
interface car_power_ctrl_if;
    logic       power_on_btn;
    logic       power_off_btn;
    logic       clutch;
    logic       throttle;
    logic       brake;
    logic       reverse;
    logic       turn_left_sw;
    logic       turn_right_sw;
    logic [1:0] state;
    logic       turn_left;
    logic       turn_right;
    logic       blink_tick;
    logic       reversing;

    modport master (
        output power_on_btn, power_off_btn, clutch, throttle, brake, reverse,
               turn_left_sw, turn_right_sw,
        input  state, turn_left, turn_right, blink_tick, reversing
    );

    modport slave (
        input  power_on_btn, power_off_btn, clutch, throttle, brake, reverse,
               turn_left_sw, turn_right_sw,
        output state, turn_left, turn_right, blink_tick, reversing
    );
endinterface

// File: rtl/car_power_ctrl.sv
// Car power/drive sequencer: turns raw pedal, gear and button levels into the car state,
// qualified turn requests and a half-period blink tick. Every output is registered.
module car_power_ctrl #(
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int BLINK_HALF  = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    car_power_ctrl_if.slave  ctl
);

    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_HALF  > 1) ? $clog2(BLINK_HALF)  : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        OFF          = 2'b00,
        NOT_STARTING = 2'b01,
        STARTING     = 2'b11,
        MOVING       = 2'b10
    } state_e;

    state_e             state_q,      state_d;
    logic [HOLD_W-1:0]  hold_q,       hold_d;
    logic [BLINK_W-1:0] blink_q,      blink_d;
    logic               blink_tick_q, blink_tick_d;
    logic               turn_left_q,  turn_left_d;
    logic               turn_right_q, turn_right_d;
    logic               reversing_q,  reversing_d;

    logic gear_mismatch;
    logic turn_allowed;
    logic turn_active_d;
    logic turn_same;

    assign gear_mismatch = (ctl.reverse != reversing_q);

    // State register, together with every other register so all outputs share one reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= OFF;
            hold_q       <= '0;
            blink_q      <= '0;
            blink_tick_q <= 1'b0;
            turn_left_q  <= 1'b0;
            turn_right_q <= 1'b0;
            reversing_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            hold_q       <= hold_d;
            blink_q      <= blink_d;
            blink_tick_q <= blink_tick_d;
            turn_left_q  <= turn_left_d;
            turn_right_q <= turn_right_d;
            reversing_q  <= reversing_d;
        end
    end

    // Next-state logic: power-off beats a stall, a stall beats the pedal rules.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
        state_d = state_q;
        hold_d  = '0;
        if (state_q == OFF) begin
            if (ctl.power_on_btn && !ctl.power_off_btn) begin
                if (hold_q == HOLD_LAST) state_d = NOT_STARTING;
                else                     hold_d  = hold_q + HOLD_W'(1);
            end
        end else if (ctl.power_off_btn) begin
            state_d = OFF;
        end else if (gear_mismatch) begin
            if (!ctl.clutch) state_d = OFF;
        end else begin
            unique case (state_q)
                NOT_STARTING: begin
                    if (ctl.throttle) state_d = ctl.clutch ? STARTING : OFF;
                end
                STARTING: begin
                    if (ctl.brake)                         state_d = NOT_STARTING;
                    else if (ctl.throttle && !ctl.clutch)  state_d = MOVING;
                end
                MOVING: begin
                    if (ctl.brake)                         state_d = NOT_STARTING;
                    else if (ctl.clutch || !ctl.throttle)  state_d = STARTING;
                end
                default: state_d = OFF;
            endcase
        end
    end

    // Output logic: next values of the registered outputs, qualified by the next state.
    always_comb begin
        reversing_d = reversing_q;
        if (state_q == OFF)
            reversing_d = ctl.reverse;
        else if (!ctl.power_off_btn && gear_mismatch && ctl.clutch)
            reversing_d = ctl.reverse;

        turn_allowed = (state_d == STARTING) || (state_d == MOVING);
        turn_left_d  = turn_allowed && ctl.turn_left_sw  && !ctl.turn_right_sw;
        turn_right_d = turn_allowed && ctl.turn_right_sw && !ctl.turn_left_sw;

        // A turn that just started, stopped or swapped sides restarts the half period.
        turn_active_d = turn_left_d ^ turn_right_d;
        turn_same     = ({turn_left_d, turn_right_d} == {turn_left_q, turn_right_q});
        blink_d       = '0;
        blink_tick_d  = 1'b0;
        if (turn_active_d && turn_same) begin
            if (blink_q == BLINK_LAST) blink_tick_d = 1'b1;
            else                       blink_d      = blink_q + BLINK_W'(1);
        end
    end

    assign ctl.state      = state_q;
    assign ctl.turn_left  = turn_left_q;
    assign ctl.turn_right = turn_right_q;
    assign ctl.blink_tick = blink_tick_q;
    assign ctl.reversing  = reversing_q;

endmodule

// File: tb/tb_car_power_ctrl.sv
// Directed bench for car_power_ctrl: stimulus queues hand-computed expectations per edge,
// and a negedge monitor pops and compares them against the registered outputs.
module tb_car_power_ctrl;

    localparam int HOLD  = 4;
    localparam int BLINK = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    car_power_ctrl_if bus ();

    car_power_ctrl #(.HOLD_CYCLES(HOLD), .BLINK_HALF(BLINK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus)
    );

    // Packed expectation: {state[1:0], turn_left, turn_right, blink_tick, reversing}
    typedef struct {
        string      name;
        int         cyc;
        logic [5:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_edges  = 0;
    int   checks   = 0;
    int   failures = 0;

    always @(posedge clk) n_edges <= n_edges + 1;

    function automatic logic [5:0] observed();
        return {bus.state, bus.turn_left, bus.turn_right, bus.blink_tick, bus.reversing};
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @edge%0d got {st,tl,tr,tk,rv}=%b_%b%b%b%b want %b_%b%b%b%b",
                     name, n_edges, got[5:4], got[3], got[2], got[1], got[0],
                     exp[5:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: every output sample due at this edge count is compared.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= n_edges) begin
            e = sb.pop_front();
            check(e.name, observed(), e.exp);
        end
    end

    // Queue the expected outputs after the coming edge, then advance to the next negedge.
    task automatic step(input string name, input logic [1:0] st,
                        input logic tl, input logic tr, input logic tk, input logic rv);
        exp_t e;
        e.name = name;
        e.cyc  = n_edges + 1;
        e.exp  = {st, tl, tr, tk, rv};
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.power_on_btn  = 1'b0;
        bus.power_off_btn = 1'b0;
        bus.clutch        = 1'b0;
        bus.throttle      = 1'b0;
        bus.brake         = 1'b0;
        bus.reverse       = 1'b0;
        bus.turn_left_sw  = 1'b0;
        bus.turn_right_sw = 1'b0;
    endtask

    // Four sampling edges with the button held; state flips on the fourth.
    task automatic power_on(input string name);
        bus.power_on_btn = 1'b1;
        for (int i = 0; i < HOLD - 1; i++) step(name, 2'b00, 0, 0, 0, 0);
        step(name, 2'b01, 0, 0, 0, 0);
        bus.power_on_btn = 1'b0;
    endtask

    task automatic drive_to_moving(input logic rv);
        bus.clutch = 1'b1; bus.throttle = 1'b1;
        step("ns_to_starting", 2'b11, 0, 0, 0, rv);
        bus.clutch = 1'b0;
        step("starting_to_moving", 2'b10, 0, 0, 0, rv);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        sb.push_back('{name: "reset_state", cyc: 1, exp: 6'b00_0000});
        @(negedge clk);
        rst_n = 1'b1;

        // Short press: three edges then release must not power on.
        bus.power_on_btn = 1'b1;
        for (int i = 0; i < 3; i++) step("short_press", 2'b00, 0, 0, 0, 0);
        bus.power_on_btn = 1'b0;
        step("short_release", 2'b00, 0, 0, 0, 0);
        power_on("power_on_full");

        drive_to_moving(1'b0);

        // Left turn in MOVING: ticks 3, 6 and 9 edges after turn_left rises.
        bus.turn_left_sw = 1'b1;
        step("turn_left_rise", 2'b10, 1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) step("blink", 2'b10, 1, 0, (i % 3) == 0, 0);

        // Both levers: neither turn, no ticks.
        bus.turn_right_sw = 1'b1;
        for (int i = 0; i < 4; i++) step("both_levers", 2'b10, 0, 0, 0, 0);

        // Brake with throttle wins; turn is suppressed outside STARTING/MOVING.
        bus.turn_right_sw = 1'b0;
        bus.brake = 1'b1;
        step("moving_brake", 2'b01, 0, 0, 0, 0);
        bus.brake = 1'b0; bus.throttle = 1'b0;
        step("ns_turn_blocked", 2'b01, 0, 0, 0, 0);
        bus.turn_left_sw = 1'b0;

        // Throttle without clutch in NOT_STARTING stalls.
        bus.throttle = 1'b1;
        step("ns_throttle_stall", 2'b00, 0, 0, 0, 0);
        bus.throttle = 1'b0;

        // Gear change without clutch in MOVING stalls; OFF then tracks the lever.
        power_on("power_on_2");
        drive_to_moving(1'b0);
        bus.reverse = 1'b1;
        step("moving_gear_stall", 2'b00, 0, 0, 0, 0);
        bus.throttle = 1'b0;
        step("off_tracks_reverse", 2'b00, 0, 0, 0, 1);
        bus.reverse = 1'b0;
        step("off_tracks_forward", 2'b00, 0, 0, 0, 0);

        // Gear change with clutch in STARTING is accepted and the state holds.
        power_on("power_on_3");
        bus.clutch = 1'b1; bus.throttle = 1'b1;
        step("ns_to_starting_3", 2'b11, 0, 0, 0, 0);
        bus.reverse = 1'b1;
        step("starting_clutch_reverse", 2'b11, 0, 0, 0, 1);
        bus.clutch = 1'b0;
        step("reverse_moving", 2'b10, 0, 0, 0, 1);

        // Power-off together with brake goes straight to OFF.
        bus.power_off_btn = 1'b1; bus.brake = 1'b1;
        step("poff_beats_brake", 2'b00, 0, 0, 0, 1);
        bus.power_off_btn = 1'b0; bus.brake = 1'b0; bus.throttle = 1'b0; bus.reverse = 1'b0;
        step("off_after_poff", 2'b00, 0, 0, 0, 0);

        // Both buttons keep it OFF and clear the hold count, so a full hold is needed after.
        bus.power_on_btn = 1'b1; bus.power_off_btn = 1'b1;
        for (int i = 0; i < 6; i++) step("both_buttons", 2'b00, 0, 0, 0, 0);
        bus.power_off_btn = 1'b0;
        power_on("power_on_after_both");

        drive_to_moving(1'b0);
        bus.turn_left_sw = 1'b1;
        step("turn_before_reset", 2'b10, 1, 0, 0, 0);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1 check("async_reset", observed(), 6'b00_0000);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        power_on("power_on_after_reset");

        for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/car_power_ctrl.md
# car_power_ctrl

Sequencing controller for the car simulation. It turns the driver's raw controls (power buttons, clutch, throttle, brake, reverse gear, turn switches) into the 2-bit car `state` and the qualified `turn_left`/`turn_right` signals consumed by the indicator-light driver. It also produces a `blink_tick` pulse, so the indicator driver toggles at a human-visible rate rather than every clock. It sits between the debounced input layer and the LED/display datapath.

## Interface
- `HOLD_CYCLES`, default 100_000_000: consecutive cycles `power_on_btn` must be high to power on (1 s at 100 MHz).
- `BLINK_HALF`, default 50_000_000: cycles between `blink_tick` pulses (half blink period).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `power_on_btn`  in  1  power-on button, debounced level.
- `power_off_btn`  in  1  power-off button, debounced level.
- `clutch`, `throttle`, `brake`  in  1 each  pedal levels.
- `reverse`  in  1  reverse gear switch level.
- `turn_left_sw`, `turn_right_sw`  in  1 each  turn lever levels.
- `state`  out  2  OFF=00, NOT_STARTING=01, STARTING=11, MOVING=10.
- `turn_left`, `turn_right`  out  1 each  qualified turn requests.
- `blink_tick`  out  1  one-cycle pulse every `BLINK_HALF` cycles while a turn is active.
- `reversing`  out  1  accepted gear direction (1 = reverse).

## Operation
- All outputs are registered. Inputs are sampled on each rising edge and are treated as synchronous.
- **Reset:** `state`=OFF, `turn_left`=`turn_right`=0, `blink_tick`=0, `reversing`=0, and all counters are 0.
- **Priority, highest first:** `power_off_btn` → stall rules → pedal rules.
- **OFF:**
  - The hold counter increments while `power_on_btn`=1 and clears when it is 0.
  - When the counter equals `HOLD_CYCLES-1` with the button still high, the next state is NOT_STARTING.
  - `reversing` silently tracks `reverse`.
- **Any state other than OFF:** `power_off_btn`=1 → OFF. The hold counter is held at 0.
- **Stall, any non-OFF state:** if `reverse` differs from `reversing` and `clutch`=0 → OFF. If `clutch`=1, `reversing` is updated to `reverse` and the state is unchanged.
- **NOT_STARTING:**
  - `throttle`=1 and `clutch`=0 → OFF (stall).
  - `throttle`=1 and `clutch`=1 → STARTING.
  - Otherwise, hold.
- **STARTING:**
  - `brake`=1 → NOT_STARTING.
  - Else `throttle`=1, `clutch`=0 → MOVING.
  - Else hold.
- **MOVING:**
  - `brake`=1 → NOT_STARTING.
  - Else `clutch`=1 or `throttle`=0 → STARTING.
  - Else hold.
- **Turn qualification:**
  - When the next state is STARTING or MOVING: `turn_left` = `turn_left_sw & ~turn_right_sw`, and `turn_right` = `turn_right_sw & ~turn_left_sw`.
  - In any other next state, both are 0.
  - Both levers on → neither.
- **Blink counter:**
  - Counts while exactly one of `turn_left`/`turn_right` is 1.
  - At count `BLINK_HALF-1`: pulse `blink_tick` for one cycle and wrap to 0.
  - Cleared to 0, with no pulse, when the turn becomes inactive, changes direction, or the state leaves STARTING/MOVING.

## Timing
- Every state change is visible one clock after the edge that sampled the condition. There is no combinational path from input to output.
- **Power-on:** `power_on_btn` high from edge k → `state`=01 after edge k+`HOLD_CYCLES-1`. A release at any edge before that restarts the count from 0.
- `power_on_btn` and `power_off_btn` both high in OFF → stays OFF and the hold counter clears.
- `power_off_btn` mid power-on count, or in any state → OFF on the next edge; turn outputs and blink counter clear on the same edge.
- **Blink:** the first `blink_tick` arrives exactly `BLINK_HALF` cycles after `turn_left`/`turn_right` first rises. Subsequent pulses come every `BLINK_HALF` cycles.
- **Simultaneous inputs:**
  - `brake` with `throttle` → brake wins.
  - Stall with `brake` → stall (OFF) wins.
- Asserting `rst_n`=0 mid-operation forces all reset values immediately, independent of `clk`.

## Test plan
Use `HOLD_CYCLES`=4 and `BLINK_HALF`=3.
- **Power-on:**
  - `power_on_btn` high 3 cycles then low → `state` stays 00.
  - Held 4 cycles → `state`=01 one clock after the 4th sampling edge.
- **Drive sequence:**
  - From 01: `clutch`=1, `throttle`=1 → 11.
  - Then `clutch`=0 → 10.
  - Then `brake`=1 → 01.
- **Stalls:**
  - In 01, `throttle`=1 with `clutch`=0 → 00.
  - In 10, toggle `reverse` with `clutch`=0 → 00.
  - In 11, toggle `reverse` with `clutch`=1 → `reversing`=1, state stays 11.
- **Turn/blink:**
  - In 10 with `turn_left_sw`=1 → `turn_left`=1; `blink_tick` pulses at 3, 6 and 9 cycles after.
  - Then set `turn_right_sw`=1 → both turn outputs 0 and no further ticks.
  - In 01, `turn_left_sw`=1 → `turn_left`=0.
- **Priority:**
  - In 10, `power_off_btn`=1 together with `brake`=1 → 00 next cycle.
  - In OFF, both power buttons held 6 cycles → stays 00.
- **Async reset:** drop `rst_n` between clock edges while in 10 with a turn active → `state`=00, all outputs 0 immediately. After release, 4 cycles of `power_on_btn` are needed to reach 01 again.
